// File: rtl/gpr_xfer_sequencer.sv
// Sequences one GPR transfer request (MOVE/SWAP/LOADI/CLEAR) into the GPR_in/GPR_out/GPR_select
// micro-cycles, staging register-to-register data through temps T0/T1 because the GPR file is half-duplex.
module gpr_xfer_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [SEL_WIDTH-1:0]  req_src,
    input  logic [SEL_WIDTH-1:0]  req_dst,
    input  logic [DATA_WIDTH-1:0] req_imm,
    inout  logic [DATA_WIDTH-1:0] DATA,
    output logic                  GPR_in,
    output logic                  GPR_out,
    output logic [SEL_WIDTH-1:0]  GPR_select,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] temp_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        WR0  = 3'd3,
        WR1  = 3'd4
    } state_t;

    localparam logic [1:0] OP_MOVE  = 2'b00;
    localparam logic [1:0] OP_SWAP  = 2'b01;
    localparam logic [1:0] OP_LOADI = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [SEL_WIDTH-1:0]  src_q, src_d;
    logic [SEL_WIDTH-1:0]  dst_q, dst_d;
    logic [DATA_WIDTH-1:0] t0_q, t0_d;
    logic [DATA_WIDTH-1:0] t1_q, t1_d;
    logic                  gpr_in_q, gpr_in_d;
    logic                  gpr_out_q, gpr_out_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  done_q, done_d;
    logic                  ready_q, ready_d;
    logic                  drive_t1_q, drive_t1_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        t0_d    = t0_q;
        t1_d    = t1_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d  = req_op;
                    src_d = req_src;
                    dst_d = req_dst;
                    case (req_op)
                        OP_MOVE:  state_d = RD0;
                        OP_SWAP:  state_d = RD0;
                        OP_LOADI: begin
                            state_d = WR0;
                            t0_d    = req_imm;
                        end
                        OP_CLEAR: begin
                            state_d = WR0;
                            t0_d    = '0;
                        end
                        default:  state_d = IDLE;
                    endcase
                end
            end
            RD0: begin
                t0_d    = DATA;
                state_d = (op_q == OP_SWAP) ? RD1 : WR0;
            end
            RD1: begin
                t1_d    = DATA;
                state_d = WR0;
            end
            WR0: begin
                if (op_q == OP_SWAP) begin
                    state_d = WR1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            WR1: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered, one flop stage, with the state.
    always_comb begin
        gpr_in_d   = 1'b0;
        gpr_out_d  = 1'b0;
        sel_d      = '0;
        drive_t1_d = 1'b0;
        ready_d    = 1'b0;

        case (state_d)
            IDLE: ready_d = 1'b1;
            RD0: begin
                gpr_out_d = 1'b1;
                sel_d     = src_d;
            end
            RD1: begin
                gpr_out_d = 1'b1;
                sel_d     = dst_d;
            end
            WR0: begin
                gpr_in_d = 1'b1;
                sel_d    = dst_d;
            end
            WR1: begin
                gpr_in_d   = 1'b1;
                sel_d      = src_d;
                drive_t1_d = 1'b1;
            end
            default: ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            t0_q       <= '0;
            t1_q       <= '0;
            gpr_in_q   <= 1'b0;
            gpr_out_q  <= 1'b0;
            sel_q      <= '0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            drive_t1_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            t0_q       <= t0_d;
            t1_q       <= t1_d;
            gpr_in_q   <= gpr_in_d;
            gpr_out_q  <= gpr_out_d;
            sel_q      <= sel_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            drive_t1_q <= drive_t1_d;
        end
    end

    // Bus is driven only while the GPR file is latching, so it never fights the file's own drivers.
    assign DATA       = gpr_in_q ? (drive_t1_q ? t1_q : t0_q) : 'z;
    assign GPR_in     = gpr_in_q;
    assign GPR_out    = gpr_out_q;
    assign GPR_select = sel_q;
    assign done       = done_q;
    assign req_ready  = ready_q;
    assign busy       = ~ready_q;
    assign temp_dbg   = t0_q;

endmodule

// File: tb/tb_gpr_xfer_sequencer.sv
// Directed and random checks of gpr_xfer_sequencer against a behavioural 8x16 GPR file and
// a reference copy of the register contents.
module tb_gpr_xfer_sequencer;

    localparam int RD1_IDX = 3;
    localparam int RD2_IDX = 5;
    localparam int RS1_IDX = 2;
    localparam int RS2_IDX = 6;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [2:0]  req_src;
    logic [2:0]  req_dst;
    logic [15:0] req_imm;
    wire  [15:0] data_bus;
    logic        GPR_in;
    logic        GPR_out;
    logic [2:0]  GPR_select;
    logic        busy;
    logic        done;
    logic [15:0] temp_dbg;

    logic [15:0] gpr [8];
    logic [15:0] ref_gpr [8];
    logic        pre_en;
    logic [2:0]  pre_idx;
    logic [15:0] pre_val;
    bit          inv_en;

    int tests;
    int fails;

    gpr_xfer_sequencer #(.DATA_WIDTH(16), .SEL_WIDTH(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_src    (req_src),
        .req_dst    (req_dst),
        .req_imm    (req_imm),
        .DATA       (data_bus),
        .GPR_in     (GPR_in),
        .GPR_out    (GPR_out),
        .GPR_select (GPR_select),
        .busy       (busy),
        .done       (done),
        .temp_dbg   (temp_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dec(input logic [2:0] s);
        case (s)
            3'b001:  return 7;
            3'b010:  return RD1_IDX;
            3'b011:  return RD2_IDX;
            3'b100:  return RS1_IDX;
            3'b101:  return RS2_IDX;
            default: return 0;
        endcase
    endfunction

    // Behavioural GPR file: drives the bus when read-enabled, latches the bus on posedge when write-enabled.
    assign data_bus = GPR_out ? gpr[dec(GPR_select)] : 16'bz;

    always @(posedge clk) begin
        if (pre_en)
            gpr[pre_idx] <= pre_val;
        else if (GPR_in)
            gpr[dec(GPR_select)] <= data_bus;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (inv_en && reset)
            chk("in_out_exclusive", {31'd0, GPR_in & GPR_out}, 32'd0);
    end

    task automatic preload(input int idx, input logic [15:0] val);
        pre_en  = 1'b1;
        pre_idx = idx[2:0];
        pre_val = val;
        ref_gpr[idx] = val;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    // Issues one request, checks latency, every write beat (select and bus value), then updates the reference.
    task automatic do_op(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d,
                         input logic [15:0] imm, input string tag, input bit noise);
        int          cyc;
        int          nwr;
        int          exp_lat;
        int          exp_nwr;
        bit          got;
        logic [15:0] w0_val;
        logic [15:0] w1_val;
        logic [15:0] old_s;
        logic [15:0] old_d;

        old_s = ref_gpr[dec(s)];
        old_d = ref_gpr[dec(d)];
        case (op)
            2'b00:   begin exp_lat = 3; exp_nwr = 1; w0_val = old_s; end
            2'b01:   begin exp_lat = 5; exp_nwr = 2; w0_val = old_s; end
            2'b10:   begin exp_lat = 2; exp_nwr = 1; w0_val = imm;   end
            default: begin exp_lat = 2; exp_nwr = 1; w0_val = 16'h0; end
        endcase
        w1_val = old_d;

        chk({tag, "_ready_before"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_src   = s;
        req_dst   = d;
        req_imm   = imm;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (noise) begin
            req_valid = 1'b1;
            req_op    = 2'b11;
            req_dst   = 3'b001;
        end

        cyc = 0;
        nwr = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (noise && cyc == exp_lat - 1)
                req_valid = 1'b0;
            if (GPR_in === 1'b1) begin
                if (nwr == 0) begin
                    chk({tag, "_wr0_sel"}, {29'd0, GPR_select}, {29'd0, d});
                    chk({tag, "_wr0_data"}, {16'd0, data_bus}, {16'd0, w0_val});
                end else begin
                    chk({tag, "_wr1_sel"}, {29'd0, GPR_select}, {29'd0, s});
                    chk({tag, "_wr1_data"}, {16'd0, data_bus}, {16'd0, w1_val});
                end
                nwr++;
            end
            if (cyc == 1)
                chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            if (done === 1'b1)
                got = 1'b1;
        end
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_writes"}, nwr, exp_nwr);
        chk({tag, "_ready_at_done"}, {31'd0, req_ready}, 32'd1);

        case (op)
            2'b00: ref_gpr[dec(d)] = old_s;
            2'b01: begin
                ref_gpr[dec(d)] = old_s;
                ref_gpr[dec(s)] = old_d;
            end
            2'b10: ref_gpr[dec(d)] = imm;
            default: ref_gpr[dec(d)] = 16'h0;
        endcase
        $display("[TB] %s op=%0d src=%0d dst=%0d imm=%h latency=%0d", tag, op, s, d, imm, cyc);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        inv_en    = 1'b0;
        pre_en    = 1'b0;
        pre_idx   = 3'd0;
        pre_val   = 16'h0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_src   = 3'b000;
        req_dst   = 3'b000;
        req_imm   = 16'h0;
        for (int i = 0; i < 8; i++) ref_gpr[i] = 16'h0;

        // Reset held with a request pending: nothing may start.
        reset     = 1'b0;
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_src   = 3'b001;
        req_dst   = 3'b010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_gpr_in", {31'd0, GPR_in}, 32'd0);
            chk("rst_gpr_out", {31'd0, GPR_out}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
        end
        chk("rst_select", {29'd0, GPR_select}, 32'd0);
        chk("rst_temp", {16'd0, temp_dbg}, 32'd0);
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chk("rst_release_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_release_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("idle_no_accept", {31'd0, req_ready}, 32'd1);
        $display("[TB] reset sequence complete");
        inv_en = 1'b1;

        for (int i = 0; i < 8; i++) preload(i, 16'h0);

        // MOVE R7 -> Rd_1 (R3)
        preload(7, 16'h1234);
        do_op(2'b00, 3'b001, 3'b010, 16'h0, "move_r7_r3", 1'b0);
        chk("move_r3", {16'd0, gpr[3]}, 32'h1234);
        chk("move_r7_kept", {16'd0, gpr[7]}, 32'h1234);
        chk("move_temp", {16'd0, temp_dbg}, 32'h1234);

        // SWAP Rs_1 (R2) <-> Rd_2 (R5), with a request held pending while busy
        preload(2, 16'hAAAA);
        preload(5, 16'h5555);
        do_op(2'b01, 3'b100, 3'b011, 16'h0, "swap_r2_r5", 1'b1);
        chk("swap_r2", {16'd0, gpr[2]}, 32'h5555);
        chk("swap_r5", {16'd0, gpr[5]}, 32'hAAAA);
        @(negedge clk);
        chk("swap_no_queued_accept", {31'd0, busy}, 32'd0);
        chk("swap_r7_untouched", {16'd0, gpr[7]}, 32'h1234);

        // LOADI then CLEAR accepted in the done cycle
        do_op(2'b10, 3'b000, 3'b010, 16'hBEEF, "loadi_r3", 1'b0);
        chk("loadi_r3", {16'd0, gpr[3]}, 32'hBEEF);
        chk("loadi_done_high", {31'd0, done}, 32'd1);
        do_op(2'b11, 3'b000, 3'b010, 16'hFFFF, "clear_r3", 1'b0);
        chk("clear_r3", {16'd0, gpr[3]}, 32'h0000);

        // SWAP with src==dst leaves the value in place
        do_op(2'b01, 3'b101, 3'b101, 16'h0, "swap_same", 1'b0);
        chk("swap_same_r6", {16'd0, gpr[6]}, {16'd0, ref_gpr[6]});

        // Reset asserted during SWAP RD1 aborts the operation
        preload(2, 16'h1111);
        preload(5, 16'h2222);
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_src   = 3'b100;
        req_dst   = 3'b011;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_rd1_out", {31'd0, GPR_out}, 32'd1);
        chk("abort_in_rd1_sel", {29'd0, GPR_select}, 32'd3);
        reset = 1'b0;
        #1;
        chk("abort_gpr_out", {31'd0, GPR_out}, 32'd0);
        chk("abort_gpr_in", {31'd0, GPR_in}, 32'd0);
        chk("abort_select", {29'd0, GPR_select}, 32'd0);
        chk("abort_temp", {16'd0, temp_dbg}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 32'd0);
            chk("abort_no_write", {31'd0, GPR_in}, 32'd0);
        end
        chk("abort_r2_kept", {16'd0, gpr[2]}, 32'h1111);
        chk("abort_r5_kept", {16'd0, gpr[5]}, 32'h2222);
        $display("[TB] mid-swap reset abort complete");

        // Random regression against the reference register model
        for (int n = 0; n < 1000; n++) begin
            logic [1:0]  rop;
            logic [2:0]  rs;
            logic [2:0]  rd;
            logic [15:0] rimm;
            rop  = 2'($urandom_range(0, 3));
            rs   = 3'($urandom_range(0, 7));
            rd   = 3'($urandom_range(0, 7));
            rimm = 16'($urandom);
            do_op(rop, rs, rd, rimm, "rand", 1'b0);
            chk("rand_dst", {16'd0, gpr[dec(rd)]}, {16'd0, ref_gpr[dec(rd)]});
        end
        for (int i = 0; i < 8; i++)
            chk("final_regs", {16'd0, gpr[i]}, {16'd0, ref_gpr[i]});

        inv_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
